multicycle_fsm: RTL
===================

Name: multicycle_fsm

Overview:
- Main control state machine of the ARM multicycle core. Sequences each instruction through fetch, decode, execute, memory and writeback.
- Sits between the instruction register and the per-instruction decode/condition logic. It consumes Op/Funct fields plus a long-multiply flag, and produces unconditioned write strobes (NextPC, RegW, RegW2, MemW, Branch) and datapath mux selects.
- Condition gating of the strobes is done downstream; this block never sees flags.

Parameters:
- HAS_MEM_WAIT, 1, 1 = memory states wait for MemReady; 0 = MemReady ignored (treated as 1).

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]; bit5 = I, bit0 = L/S
- LongMul  in  1  decoded two-destination multiply (valid while IR holds the instruction)
- MemReady  in  1  memory completes the current access this cycle
- IRWrite  out  1  load instruction register
- AdrSrc  out  1  0 = PC, 1 = ALUOut as memory address
- ALUSrcA  out  2  00 = RegA, 01 = PC, 10 = ALUOut
- ALUSrcB  out  2  00 = RegB, 01 = ExtImm, 10 = constant 4
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUOp  out  1  1 = ALU function from Funct; 0 = add
- NextPC  out  1  unconditional PC write
- RegW  out  1  register write, first destination
- RegW2  out  1  register write, second destination
- MemW  out  1  memory write
- Branch  out  1  branch instruction in branch state
- State  out  4  current state, debug/verification

Behaviour:
- Moore machine: every output is a function of the registered state, except MemReady gating (below). One state register, updated on the rising edge of clk.
- reset high at an edge: state <= FETCH, regardless of current state (mid-instruction abort allowed).
- While reset is high, IRWrite, NextPC, RegW, RegW2, MemW and Branch are forced to 0. Selects show their FETCH values.

States and outputs (unlisted outputs = 0 / 00):
- FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10. IRWrite and NextPC = MemReady. Goes to DECODE when MemReady, else stays.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - Op=01 -> MEMADR
  - Op=00 and Funct[5]=0 -> EXECUTER
  - Op=00 and Funct[5]=1 -> EXECUTEI
  - Op=10 -> BRANCH
  - Op=11 -> FETCH (undefined instruction, no strobes)
- MEMADR: ALUSrcA=00, ALUSrcB=01. Funct[0]=1 -> MEMREAD, else MEMWRITE.
- MEMREAD: AdrSrc=1. -> MEMWB when MemReady, else stays.
- MEMWB: ResultSrc=01, RegW=1. -> FETCH.
- MEMWRITE: AdrSrc=1, MemW = MemReady. -> FETCH when MemReady, else stays.
- EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1. -> ALUWB.
- EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUOp=1. -> ALUWB.
- ALUWB: ResultSrc=00, RegW=1. -> ALUWB2 if LongMul, else FETCH.
- ALUWB2: ResultSrc=00, RegW2=1. -> FETCH.
- BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, Branch=1. -> FETCH.

Other rules:
- Illegal or unused state encodings -> FETCH next cycle, with all strobes 0.
- MemW and IRWrite are each asserted for exactly one cycle per access: the cycle MemReady is seen.
- Cycle counts with zero wait:
  - Data-processing: 4 cycles (5 with LongMul)
  - LDR: 5 cycles
  - STR: 4 cycles
  - B: 3 cycles
- Each cycle of MemReady=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Op/Funct/LongMul are sampled only in DECODE, MEMADR and ALUWB. Changes to them in other states have no effect.

Decomposition:
- Shared package ctrl_pkg holds:
  - state enum (4-bit, FETCH=0)
  - ALUSrcA, ALUSrcB and ResultSrc encodings
  - Op encodings (OP_DP=00, OP_MEM=01, OP_BR=10)
- Output decoding is a single case on state inside this module; no sub-module is needed.

Test Plan:
- Reset held 2 cycles, then released with MemReady=1 -> State=FETCH, all strobes 0 during reset. IRWrite=NextPC=1 on the first cycle after release.
- ADD register (Op=00, Funct=001000, LongMul=0) -> state sequence FETCH, DECODE, EXECUTER, ALUWB, FETCH. RegW=1 only in ALUWB; ALUOp=1 only in EXECUTER.
- LDR (Op=01, Funct=011001) with MemReady low for 2 cycles in MEMREAD -> MEMREAD held 3 cycles, then MEMWB with ResultSrc=01 and RegW=1. Total 7 cycles.
- STR (Op=01, Funct=011000) with MemReady=0 for 1 cycle in MEMWRITE -> MemW=0 then MemW=1 for exactly one cycle, then FETCH.
- UMULL-class (Op=00, Funct=000000, LongMul=1) -> ALUWB (RegW=1, RegW2=0) then ALUWB2 (RegW2=1, RegW=0), then FETCH.
- B (Op=10) with reset asserted while in BRANCH -> Branch forced 0 in that cycle, State=FETCH next cycle. Op=11 -> DECODE returns to FETCH with no strobes.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: state enum, datapath mux
// selects, opcode classes and the decoded control bundle.
package ctrl_pkg;

  localparam int unsigned STATE_W   = 4;
  localparam int unsigned OP_W      = 2;
  localparam int unsigned FUNCT_W   = 6;
  localparam int unsigned SEL_W     = 2;
  localparam int unsigned FUNCT_I   = 5;
  localparam int unsigned FUNCT_L   = 0;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_ALUWB2   = 4'd9,
    S_BRANCH   = 4'd10
  } state_e;

  localparam logic [SEL_W-1:0] SRCA_REG    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_PC     = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_REG    = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM    = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'b10;

  localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
  localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

  localparam logic [OP_W-1:0] OP_DP  = 2'b00;
  localparam logic [OP_W-1:0] OP_MEM = 2'b01;
  localparam logic [OP_W-1:0] OP_BR  = 2'b10;
  localparam logic [OP_W-1:0] OP_UND = 2'b11;

  // Unconditioned strobes and mux selects produced for one state.
  typedef struct packed {
    logic             ir_write;
    logic             adr_src;
    logic [SEL_W-1:0] alu_src_a;
    logic [SEL_W-1:0] alu_src_b;
    logic [SEL_W-1:0] result_src;
    logic             alu_op;
    logic             next_pc;
    logic             reg_w;
    logic             reg_w2;
    logic             mem_w;
    logic             branch;
  } ctrl_out_t;

  // FETCH decode; also used during reset with mem_ready forced low.
  function automatic ctrl_out_t fetch_out(input logic mem_ready);
    ctrl_out_t o;
    o            = '0;
    o.adr_src    = 1'b0;
    o.alu_src_a  = SRCA_PC;
    o.alu_src_b  = SRCB_FOUR;
    o.result_src = RES_ALURESULT;
    o.ir_write   = mem_ready;
    o.next_pc    = mem_ready;
    return o;
  endfunction

endpackage

// File: rtl/multicycle_fsm_if.sv
// Instruction-field inputs, memory handshake and control outputs of the
// multicycle controller.
interface multicycle_fsm_if;
  import ctrl_pkg::*;

  logic [OP_W-1:0]    Op;
  logic [FUNCT_W-1:0] Funct;
  logic               LongMul;
  logic               MemReady;

  logic               IRWrite;
  logic               AdrSrc;
  logic [SEL_W-1:0]   ALUSrcA;
  logic [SEL_W-1:0]   ALUSrcB;
  logic [SEL_W-1:0]   ResultSrc;
  logic               ALUOp;
  logic               NextPC;
  logic               RegW;
  logic               RegW2;
  logic               MemW;
  logic               Branch;
  logic [STATE_W-1:0] State;

  modport master (
    input  Op, Funct, LongMul, MemReady,
    output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
           NextPC, RegW, RegW2, MemW, Branch, State
  );

  modport slave (
    output Op, Funct, LongMul, MemReady,
    input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
           NextPC, RegW, RegW2, MemW, Branch, State
  );

endinterface

// File: rtl/multicycle_fsm.sv
// Main control FSM of the multicycle ARM core: fetch/decode/execute/memory/
// writeback sequencing with Moore outputs and MemReady-gated memory strobes.
module multicycle_fsm
  import ctrl_pkg::*;
#(
  parameter bit HAS_MEM_WAIT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  multicycle_fsm_if.master bus
);

  state_e    state_q;
  state_e    state_d;
  ctrl_out_t out_c;
  logic      mem_ready_c;
  logic      unused_funct_c;

  assign mem_ready_c    = HAS_MEM_WAIT ? bus.MemReady : 1'b1;
  assign unused_funct_c = ^bus.Funct[FUNCT_I-1:FUNCT_L+1];

  // State register; reset may abort an instruction at any point.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d = S_FETCH;
    out_c   = '0;

    case (state_q)
      S_FETCH: begin
        out_c   = fetch_out(mem_ready_c);
        state_d = mem_ready_c ? S_DECODE : S_FETCH;
      end

      S_DECODE: begin
        out_c.alu_src_a  = SRCA_PC;
        out_c.alu_src_b  = SRCB_FOUR;
        out_c.result_src = RES_ALURESULT;
        case (bus.Op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = bus.Funct[FUNCT_I] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end

      S_MEMADR: begin
        out_c.alu_src_a = SRCA_REG;
        out_c.alu_src_b = SRCB_IMM;
        state_d = bus.Funct[FUNCT_L] ? S_MEMREAD : S_MEMWRITE;
      end

      S_MEMREAD: begin
        out_c.adr_src = 1'b1;
        state_d = mem_ready_c ? S_MEMWB : S_MEMREAD;
      end

      S_MEMWB: begin
        out_c.result_src = RES_DATA;
        out_c.reg_w      = 1'b1;
        state_d          = S_FETCH;
      end

      // Write strobe only in the cycle the memory accepts it.
      S_MEMWRITE: begin
        out_c.adr_src = 1'b1;
        out_c.mem_w   = mem_ready_c;
        state_d = mem_ready_c ? S_FETCH : S_MEMWRITE;
      end

      S_EXECUTER: begin
        out_c.alu_src_a = SRCA_REG;
        out_c.alu_src_b = SRCB_REG;
        out_c.alu_op    = 1'b1;
        state_d         = S_ALUWB;
      end

      S_EXECUTEI: begin
        out_c.alu_src_a = SRCA_REG;
        out_c.alu_src_b = SRCB_IMM;
        out_c.alu_op    = 1'b1;
        state_d         = S_ALUWB;
      end

      S_ALUWB: begin
        out_c.result_src = RES_ALUOUT;
        out_c.reg_w      = 1'b1;
        state_d = bus.LongMul ? S_ALUWB2 : S_FETCH;
      end

      S_ALUWB2: begin
        out_c.result_src = RES_ALUOUT;
        out_c.reg_w2     = 1'b1;
        state_d          = S_FETCH;
      end

      S_BRANCH: begin
        out_c.alu_src_a  = SRCA_REG;
        out_c.alu_src_b  = SRCB_IMM;
        out_c.result_src = RES_ALURESULT;
        out_c.branch     = 1'b1;
        state_d          = S_FETCH;
      end

      default: begin
        out_c   = '0;
        state_d = S_FETCH;
      end
    endcase

    // Reset kills every strobe and presents the FETCH selects.
    if (reset) begin
      out_c = fetch_out(1'b0);
    end
  end

  assign bus.IRWrite   = out_c.ir_write;
  assign bus.AdrSrc    = out_c.adr_src;
  assign bus.ALUSrcA   = out_c.alu_src_a;
  assign bus.ALUSrcB   = out_c.alu_src_b;
  assign bus.ResultSrc = out_c.result_src;
  assign bus.ALUOp     = out_c.alu_op;
  assign bus.NextPC    = out_c.next_pc;
  assign bus.RegW      = out_c.reg_w;
  assign bus.RegW2     = out_c.reg_w2;
  assign bus.MemW      = out_c.mem_w;
  assign bus.Branch    = out_c.branch;
  assign bus.State     = STATE_W'(state_q);

endmodule
